// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive frame checker:
//   - par_typ_e  : encoding of the par_typ configuration input
//   - rx_state_e : encoding of the frame FSM states
//   - exp_parity : expected parity bit from the running XOR accumulator
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } rx_state_e;

  // Expected parity bit on the line given the XOR of all data bits.
  function automatic logic exp_parity(input logic acc, input logic [1:0] typ);
    logic p;
    p = 1'b0;
    case (par_typ_e'(typ))
      PAR_EVEN:  p = acc;
      PAR_ODD:   p = ~acc;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// ---------------------------------------------------------------------------
// uart_sat_cnt
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (count -> 0)
//   inc  : increment by one unless already at all-ones
//   clr  : synchronous clear, wins over a coincident inc
//   cnt  : current count
// ---------------------------------------------------------------------------
module uart_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_check
// Assembles a UART frame from mid-bit samples delivered by an upstream
// oversampler, checks parity and stop bits, and keeps saturating totals of
// parity and stop errors.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   frame_start    : one-cycle pulse, start bit validated (aborts a frame in
//                    progress and starts a fresh one)
//   bit_valid      : one-cycle strobe, sampled_bit is a mid-bit sample
//   sampled_bit    : sampled line value
//   par_en         : parity bit present (latched at frame_start)
//   par_typ        : 00 even, 01 odd, 10 mark, 11 space (latched)
//   two_stop       : two stop bits (latched)
//   cnt_clr        : synchronous clear of both error counters
//   p_data         : received data word, LSB first on the line
//   frame_valid    : one-cycle pulse after the last stop-bit sample
//   par_err        : parity error of the last completed frame
//   stp_err        : stop-bit error of the last completed frame
//   busy           : receiver is not idle
//   par_err_cnt    : saturating count of parity errors
//   stp_err_cnt    : saturating count of stop errors
// ---------------------------------------------------------------------------
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 sampled_bit,
  input  logic                 par_en,
  input  logic [1:0]           par_typ,
  input  logic                 two_stop,
  input  logic                 cnt_clr,
  output logic [DATA_W-1:0]    p_data,
  output logic                 frame_valid,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] par_err_cnt,
  output logic [ERR_CNT_W-1:0] stp_err_cnt
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  rx_state_e          state_q, state_d;

  // Frame working registers
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               acc_q, acc_d;
  logic               par_flag_q, par_flag_d;
  logic               stp_flag_q, stp_flag_d;

  // Configuration latched at frame_start
  logic               cfg_par_en_q, cfg_par_en_d;
  logic [1:0]         cfg_par_typ_q, cfg_par_typ_d;
  logic               cfg_two_stop_q, cfg_two_stop_d;

  // Output registers
  logic [DATA_W-1:0]  p_data_q, p_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;
  logic               busy_q, busy_d;

  // A strobe coincident with frame_start belongs to the start bit, not the frame.
  logic bit_s;
  logic last_data_s;
  logic final_stop_s;
  logic frame_stp_s;
  logic par_inc_s;
  logic stp_inc_s;

  assign bit_s        = bit_valid & ~frame_start;
  assign last_data_s  = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign final_stop_s = bit_s & (((state_q == ST_STOP1) & ~cfg_two_stop_q) |
                                 (state_q == ST_STOP2));
  // Stop flag including the sample being consumed on the final stop bit.
  assign frame_stp_s  = stp_flag_q | ~sampled_bit;
  assign par_inc_s    = final_stop_s & par_flag_q;
  assign stp_inc_s    = final_stop_s & frame_stp_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; frame_start always (re)enters DATA.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_DATA;
    end else if (bit_s) begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_DATA: begin
          if (last_data_s) begin
            state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: state_d = ST_STOP1;
        ST_STOP1:  state_d = cfg_two_stop_q ? ST_STOP2 : ST_IDLE;
        ST_STOP2:  state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame datapath: shift register, parity accumulator, bit count, flags, config.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    acc_d          = acc_q;
    par_flag_d     = par_flag_q;
    stp_flag_d     = stp_flag_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_typ_d  = cfg_par_typ_q;
    cfg_two_stop_d = cfg_two_stop_q;
    if (frame_start) begin
      bit_cnt_d      = '0;
      shift_d        = '0;
      acc_d          = 1'b0;
      par_flag_d     = 1'b0;
      stp_flag_d     = 1'b0;
      cfg_par_en_d   = par_en;
      cfg_par_typ_d  = par_typ;
      cfg_two_stop_d = two_stop;
    end else if (bit_s) begin
      case (state_q)
        ST_DATA: begin
          // Per-bit compare keeps the select index width-matched for any DATA_W.
          for (int i = 0; i < DATA_W; i++) begin
            shift_d[i] = (bit_cnt_q == CNT_W'(i)) ? sampled_bit : shift_q[i];
          end
          acc_d     = acc_q ^ sampled_bit;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        ST_PARITY: begin
          if (sampled_bit != exp_parity(acc_q, cfg_par_typ_q)) begin
            par_flag_d = 1'b1;
          end else begin
            par_flag_d = par_flag_q;
          end
        end
        ST_STOP1, ST_STOP2: begin
          if (!sampled_bit) begin
            stp_flag_d = 1'b1;
          end else begin
            stp_flag_d = stp_flag_q;
          end
        end
        default: begin
          bit_cnt_d = bit_cnt_q;
        end
      endcase
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    p_data_d      = p_data_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    frame_valid_d = final_stop_s;
    busy_d        = (state_d != ST_IDLE);
    if (final_stop_s) begin
      p_data_d  = shift_q;
      par_err_d = par_flag_q;
      stp_err_d = frame_stp_s;
    end else begin
      p_data_d  = p_data_q;
    end
  end

  // Datapath, configuration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      acc_q          <= 1'b0;
      par_flag_q     <= 1'b0;
      stp_flag_q     <= 1'b0;
      cfg_par_en_q   <= 1'b0;
      cfg_par_typ_q  <= 2'b00;
      cfg_two_stop_q <= 1'b0;
      p_data_q       <= '0;
      frame_valid_q  <= 1'b0;
      par_err_q      <= 1'b0;
      stp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      acc_q          <= acc_d;
      par_flag_q     <= par_flag_d;
      stp_flag_q     <= stp_flag_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_typ_q  <= cfg_par_typ_d;
      cfg_two_stop_q <= cfg_two_stop_d;
      p_data_q       <= p_data_d;
      frame_valid_q  <= frame_valid_d;
      par_err_q      <= par_err_d;
      stp_err_q      <= stp_err_d;
      busy_q         <= busy_d;
    end
  end

  // Counters update on the same edge that raises frame_valid.
  uart_sat_cnt #(.W(ERR_CNT_W)) u_par_cnt (
    .clk (clk),
    .rst (rst),
    .inc (par_inc_s),
    .clr (cnt_clr),
    .cnt (par_err_cnt)
  );

  uart_sat_cnt #(.W(ERR_CNT_W)) u_stp_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stp_inc_s),
    .clr (cnt_clr),
    .cnt (stp_err_cnt)
  );

  assign p_data      = p_data_q;
  assign frame_valid = frame_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_check
// Directed bench for uart_rx_frame_check (DATA_W=8, ERR_CNT_W=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_check;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       bit_valid;
  logic       sampled_bit;
  logic       par_en;
  logic [1:0] par_typ;
  logic       two_stop;
  logic       cnt_clr;
  logic [7:0] p_data;
  logic       frame_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;
  logic [1:0] par_err_cnt;
  logic [1:0] stp_err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;
  int fv_base  = 0;

  uart_rx_frame_check #(.DATA_W(8), .ERR_CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .sampled_bit (sampled_bit),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .two_stop    (two_stop),
    .cnt_clr     (cnt_clr),
    .p_data      (p_data),
    .frame_valid (frame_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid pulses seen at falling edges.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic pe, input logic [1:0] pt, input logic ts);
    par_en   = pe;
    par_typ  = pt;
    two_stop = ts;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic strobe(input logic b, input logic clr);
    @(negedge clk);
    bit_valid   = 1'b1;
    sampled_bit = b;
    cnt_clr     = clr;
    @(negedge clk);
    bit_valid   = 1'b0;
    sampled_bit = 1'b1;
    cnt_clr     = 1'b0;
  endtask

  // Data bits LSB first, optional parity bit, one or two stop bits.
  // Returns just after the edge that follows the final stop strobe.
  task automatic send_body(input logic [7:0] d, input logic has_par, input logic pbit,
                           input logic two, input logic s1, input logic s2, input logic clr);
    for (int i = 0; i < 8; i++) strobe(d[i], 1'b0);
    if (has_par) strobe(pbit, 1'b0);
    if (two) begin
      strobe(s1, 1'b0);
      strobe(s2, clr);
    end else begin
      strobe(s1, clr);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic two, input logic s1, input logic s2, input logic clr);
    pulse_start();
    send_body(d, has_par, pbit, two, s1, s2, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b1;
    cnt_clr = 1'b0;
    set_cfg(1'b0, 2'b00, 1'b0);
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check_eq("rst_p_data", p_data, 32'h0);
    check_eq("rst_fv", frame_valid, 32'h0);
    check_eq("rst_par_err", par_err, 32'h0);
    check_eq("rst_stp_err", stp_err, 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_cnts", {par_err_cnt, stp_err_cnt}, 32'h0);

    // Stray strobe in IDLE is ignored
    strobe(1'b0, 1'b0);
    check_eq("idle_strobe_busy", busy, 32'h0);

    // Even parity, 0xA5 (four ones -> parity 0), one stop
    set_cfg(1'b1, 2'b00, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("a5_fv", frame_valid, 32'h1);
    check_eq("a5_data", p_data, 32'hA5);
    check_eq("a5_par_err", par_err, 32'h0);
    check_eq("a5_stp_err", stp_err, 32'h0);
    idle(1);
    check_eq("a5_fv_one_cycle", frame_valid, 32'h0);
    check_eq("a5_busy", busy, 32'h0);
    check_eq("a5_cnts", {par_err_cnt, stp_err_cnt}, 32'h0);

    // Odd parity, 0x03 needs parity 1; send 0
    set_cfg(1'b1, 2'b01, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("odd_bad_par_err", par_err, 32'h1);
    idle(2);
    check_eq("odd_bad_par_cnt", par_err_cnt, 32'h1);

    // Same data, parity disabled, no parity bit
    set_cfg(1'b0, 2'b01, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("nopar_fv", frame_valid, 32'h1);
    check_eq("nopar_par_err", par_err, 32'h0);
    check_eq("nopar_data", p_data, 32'h03);

    // Odd parity, 0x07 (three ones) needs parity 0; send 0
    set_cfg(1'b1, 2'b01, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("odd_ok_par_err", par_err, 32'h0);

    // Two stop bits, 0x5A, stops 1 then 0
    set_cfg(1'b0, 2'b00, 1'b1);
    pulse_start();
    for (int i = 0; i < 8; i++) strobe(((8'h5A >> i) & 8'h01) != 8'h00, 1'b0);
    strobe(1'b1, 1'b0);
    check_eq("two_stop_mid_fv", frame_valid, 32'h0);
    check_eq("two_stop_mid_busy", busy, 32'h1);
    strobe(1'b0, 1'b0);
    check_eq("two_stop_fv", frame_valid, 32'h1);
    check_eq("two_stop_data", p_data, 32'h5A);
    check_eq("two_stop_stp_err", stp_err, 32'h1);
    idle(2);
    check_eq("two_stop_stp_cnt", stp_err_cnt, 32'h1);

    // Mark parity, bit 1 is correct
    set_cfg(1'b1, 2'b10, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("mark_par_err", par_err, 32'h0);
    check_eq("mark_stp_err", stp_err, 32'h0);

    // Space parity, bit 1 is wrong
    set_cfg(1'b1, 2'b11, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("space_par_err", par_err, 32'h1);
    idle(2);
    check_eq("space_par_cnt", par_err_cnt, 32'h2);

    // Abort after 4 bits, then full 0x3C frame with config changed mid-frame
    pulse_clr();
    idle(1);
    check_eq("clr_cnts", {par_err_cnt, stp_err_cnt}, 32'h0);
    fv_base = fv_cnt;
    set_cfg(1'b1, 2'b00, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) strobe(i[0], 1'b0);
    pulse_start();
    check_eq("abort_busy", busy, 32'h1);
    check_eq("abort_p_data_held", p_data, 32'h81);
    set_cfg(1'b0, 2'b01, 1'b1);
    send_body(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("abort_fv", frame_valid, 32'h1);
    check_eq("abort_data", p_data, 32'h3C);
    check_eq("abort_par_err", par_err, 32'h0);
    check_eq("abort_stp_err", stp_err, 32'h0);
    idle(2);
    check_eq("abort_fv_count", fv_cnt - fv_base, 32'h1);
    check_eq("abort_cnts", {par_err_cnt, stp_err_cnt}, 32'h0);
    check_eq("abort_idle_busy", busy, 32'h0);

    // Stop-error frames saturate the 2-bit counter at 3
    set_cfg(1'b0, 2'b00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      if (k == 1) check_eq("sat_cnt_1", stp_err_cnt, 32'h1);
      if (k == 3) check_eq("sat_cnt_3", stp_err_cnt, 32'h3);
    end
    check_eq("sat_cnt_5", stp_err_cnt, 32'h3);
    check_eq("sat_stp_err", stp_err, 32'h1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check_eq("clr_wins", stp_err_cnt, 32'h0);
    check_eq("sat_par_cnt", par_err_cnt, 32'h0);

    // One more stop error so reset has a nonzero counter to clear
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_eq("pre_rst_cnt", stp_err_cnt, 32'h1);

    // Reset in the middle of DATA
    fv_base = fv_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_p_data", p_data, 32'h0);
    check_eq("mid_rst_stp_err", stp_err, 32'h0);
    check_eq("mid_rst_busy", busy, 32'h0);
    check_eq("mid_rst_cnt", stp_err_cnt, 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("post_rst_fv", frame_valid, 32'h1);
    check_eq("post_rst_data", p_data, 32'hFF);
    check_eq("post_rst_errs", {par_err, stp_err}, 32'h0);
    idle(2);
    check_eq("post_rst_fv_count", fv_cnt - fv_base, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_check.md
UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, width of each saturating error counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse: start bit validated.
REQ-007 bit_valid  input  1  one-cycle strobe: sampled_bit holds a mid-bit sample.
REQ-008 sampled_bit  input  1  sampled line value.
REQ-009 par_en  input  1  parity bit present in the frame.
REQ-010 par_typ  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
REQ-011 two_stop  input  1  frame carries two stop bits.
REQ-012 cnt_clr  input  1  synchronous clear of both error counters.
REQ-013 p_data  output  DATA_W  received data, LSB first on the line.
REQ-014 frame_valid  output  1  one-cycle pulse: frame complete.
REQ-015 par_err  output  1  parity mismatch for the last frame.
REQ-016 stp_err  output  1  stop-bit error for the last frame.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 par_err_cnt / stp_err_cnt  output  ERR_CNT_W each  saturating error totals.

Function
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP1, STOP2.
REQ-020 IDLE->DATA on frame_start; par_en, par_typ and two_stop SHALL be latched that cycle and held for the frame.
REQ-021 In DATA, each bit_valid SHALL shift sampled_bit into the data register at bit index = count, and XOR it into a running parity accumulator; after DATA_W bits -> PARITY if latched par_en, else STOP1.
REQ-022 Expected parity bit: even = accumulator; odd = ~accumulator; mark = 1; space = 0. In PARITY, one bit_valid compares the sample against it; mismatch sets the frame parity flag; -> STOP1.
REQ-023 In STOP1/STOP2, each bit_valid with sampled_bit=0 sets the frame stop flag; STOP1 -> STOP2 if latched two_stop, else -> IDLE; STOP2 -> IDLE.
REQ-024 On the cycle after the final stop-bit bit_valid, frame_valid SHALL pulse for exactly one cycle; p_data, par_err and stp_err update on that same cycle and hold until the next frame_valid.
REQ-025 par_err SHALL be 0 for frames whose latched par_en=0.
REQ-026 bit_valid in IDLE SHALL be ignored; bit_valid coincident with frame_start SHALL be ignored.
REQ-027 frame_start while busy SHALL abort the current frame: no frame_valid, outputs unchanged, no counter update; accumulator, bit count and frame flags clear; config re-latched; state -> DATA.
REQ-028 On frame_valid, each counter whose flag is set SHALL increment by 1, saturating at 2^ERR_CNT_W-1.
REQ-029 cnt_clr SHALL zero both counters next cycle and SHALL take priority over a coincident increment.
REQ-030 Config input changes mid-frame SHALL have no effect until the next frame_start.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, and set p_data, frame_valid, par_err, stp_err, busy, both counters, the accumulator and the bit count to 0.
REQ-032 Reset mid-frame SHALL discard the frame with no frame_valid; the first frame_start after deassertion SHALL begin a clean frame.

Structure
REQ-033 Package uart_rx_pkg SHALL hold the par_typ encodings and the FSM state encoding.
REQ-034 Saturating counter SHALL be one sub-module, uart_sat_cnt (parameter W; ports clk, rst, inc, clr, cnt), instantiated twice.

Verification
REQ-035 DATA_W=8, even parity, one stop bit, data 0xA5, parity bit 0, stop 1 -> frame_valid one cycle after stop strobe, p_data=0xA5, par_err=0, stp_err=0.
REQ-036 Odd parity, data 0x03, parity bit 0 -> par_err=1, par_err_cnt 0->1; same frame with par_en=0 and no parity bit sent -> par_err=0.
REQ-037 two_stop=1, data 0x5A, stop bits 1 then 0 -> stp_err=1, stp_err_cnt increments; mark mode with parity bit 1 -> par_err=0.
REQ-038 frame_start after 4 of 8 data bits, then full frame with data 0x3C -> single frame_valid, p_data=0x3C, counters unchanged.
REQ-039 ERR_CNT_W=2, five stop-error frames -> stp_err_cnt=3 (saturated); cnt_clr coincident with 6th error frame -> stp_err_cnt=0.
REQ-040 rst asserted mid-DATA -> all outputs 0 immediately, busy=0, no frame_valid; next full frame with data 0xFF received correctly.
